// File: rtl/pipe_full_add_pkg.sv
// Sizing helpers for the pipelined adder: chunk width per stage and split legality.
package pipe_full_add_pkg;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit split_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational N-bit ripple-carry adder built from per-bit full-adder cells.
module add_chunk #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/pipe_full_add.sv
// Pipelined add/sub: each stage ripples one chunk and forwards its carry,
// with a single global advance enable driven by the output handshake.
module pipe_full_add
    import pipe_full_add_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'({CHUNK{1'b1}});

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("pipe_full_add: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic advance;

    // Per-stage combinational inputs and next values
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] d_next [STAGES];
    logic [CHUNK-1:0] sum_k  [STAGES];
    logic [STAGES-1:0] carry_in, carry_out, v_in, sa_in;

    // Stage registers; d_q holds finished sum slices below the current chunk and raw A above it
    logic [WIDTH-1:0] d_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [STAGES-1:0] c_q, v_q, sa_q;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SLICE_MASK = LOW_MASK << (k * CHUNK);

        if (k == 0) begin : g_head
            assign a_in[k]     = in1;
            assign b_in[k]     = sub ? ~in2 : in2;
            assign carry_in[k] = sub ? 1'b1 : c_in;
            assign v_in[k]     = in_valid;
            assign sa_in[k]    = in1[WIDTH-1];
        end else begin : g_body
            assign a_in[k]     = d_q[k-1];
            assign b_in[k]     = b_q[k-1];
            assign carry_in[k] = c_q[k-1];
            assign v_in[k]     = v_q[k-1];
            assign sa_in[k]    = sa_q[k-1];
        end

        add_chunk #(.N(CHUNK)) u_chunk (
            .a    (a_in[k][k*CHUNK +: CHUNK]),
            .b    (b_in[k][k*CHUNK +: CHUNK]),
            .cin  (carry_in[k]),
            .sum  (sum_k[k]),
            .cout (carry_out[k])
        );

        assign d_next[k] = (a_in[k] & ~SLICE_MASK) | (WIDTH'(sum_k[k]) << (k * CHUNK));
    end

    // Data only loads for valid entries so bubbles never disturb the held output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            c_q  <= '0;
            sa_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                if (v_in[k]) begin
                    d_q[k]  <= d_next[k];
                    b_q[k]  <= b_in[k];
                    c_q[k]  <= carry_out[k];
                    sa_q[k] <= sa_in[k];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out       = {c_q[STAGES-1], d_q[STAGES-1]};
    assign ovf       = (sa_q[STAGES-1] == b_q[STAGES-1][WIDTH-1]) &&
                       (d_q[STAGES-1][WIDTH-1] != sa_q[STAGES-1]);

endmodule
